// File: rtl/imem_server.sv
// imem_server: input-memory responder for the convolution array.
//
// Holds the binary ifmap (one IFMAP_SIZE-bit row per word). After start it primes every
// partial-sum PE with its first row, then answers each PE request with the PE's next row,
// and with a done packet once that PE's OUTPUT_DIM rows are exhausted.
//
// Optional feature macro: IMEM_REQ_CHECK_EN
//   defined   : malformed requests (wrong dest, opcode != 0, id >= NUM_PE) are dropped and
//               the sticky err flag is raised.
//   undefined : no checks, err tied low.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ld_en/ld_row/ld_data ifmap row write port (ignored while busy)
//   start               one-cycle pulse that begins a pass (ignored while busy)
//   in_valid/in_ready/in_data     request channel, packet {dest[3:0], op[3:0], data[24:0]}
//   out_valid/out_ready/out_data  reply channel, same packet format
//   busy, done, err     status
module imem_server #(
  parameter int unsigned IMEM_ID     = 10,
  parameter int unsigned NUM_PE      = 5,
  parameter int unsigned FILTER_SIZE = 5,
  parameter int unsigned IFMAP_SIZE  = 25,
  parameter int unsigned OUTPUT_DIM  = IFMAP_SIZE - FILTER_SIZE + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_en,
  input  logic [4:0]            ld_row,
  input  logic [IFMAP_SIZE-1:0] ld_data,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32:0]           out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPrime = 2'd1;
  localparam logic [1:0] StServe = 2'd2;
  localparam logic [1:0] StReply = 2'd3;

  localparam logic [3:0] OpRow  = 4'd1;
  localparam logic [3:0] OpDone = 4'd2;

  localparam logic [4:0] OutDim = 5'(OUTPUT_DIM);
  localparam logic [3:0] LastPe = 4'(NUM_PE - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            pe_q, pe_d;
  logic [4:0]            cnt_q [NUM_PE];
  logic [4:0]            cnt_d [NUM_PE];
  logic [NUM_PE-1:0]     fin_q, fin_d;
  logic                  out_valid_q, out_valid_d;
  logic [32:0]           out_data_q, out_data_d;
  logic                  done_q, done_d;
  logic                  req_bad;

  // Ifmap storage: deliberately not reset so loaded rows survive rst_n.
  logic [IFMAP_SIZE-1:0] mem [IFMAP_SIZE];

  always_ff @(posedge clk) begin
    if (ld_en && !busy && (ld_row < 5'(IFMAP_SIZE))) begin
      mem[ld_row] <= ld_data;
    end
  end

  // Row lookup for the PE being answered: during PRIME it is the packet about to be loaded
  // (pe_q, or pe_q+1 when the current one is being accepted); otherwise the requester id.
  logic [3:0]            sel_id;
  logic [4:0]            sel_cnt;
  logic [5:0]            rd_sum;
  logic [4:0]            rd_idx;
  logic [IFMAP_SIZE-1:0] rd_row;
  logic [24:0]           row_field;

  always_comb begin
    if (state_q == StPrime) begin
      sel_id = out_valid_q ? pe_q + 4'd1 : pe_q;
    end else begin
      sel_id = in_data[3:0];
    end
    sel_cnt = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (sel_id == 4'(k)) sel_cnt = cnt_q[k];
    end
    rd_sum = {2'b00, sel_id} + {1'b0, sel_cnt};
    // Out-of-range ids (unchecked build) must not index past the array.
    rd_idx = (rd_sum < 6'(IFMAP_SIZE)) ? rd_sum[4:0] : 5'd0;
  end

  assign rd_row    = mem[rd_idx];
  assign row_field = 25'(rd_row);

  always_comb begin
    state_d     = state_q;
    pe_d        = pe_q;
    cnt_d       = cnt_q;
    fin_d       = fin_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPrime;
          pe_d    = '0;
          for (int k = 0; k < NUM_PE; k++) cnt_d[k] = '0;
          fin_d   = '0;
          done_d  = 1'b0;
        end
      end
      StPrime: begin
        if (!out_valid_q || out_ready) begin
          if (out_valid_q && (pe_q == LastPe)) begin
            out_valid_d = 1'b0;
            state_d     = StServe;
          end else begin
            // Back-to-back load keeps priming at one packet per cycle.
            pe_d        = sel_id;
            out_valid_d = 1'b1;
            out_data_d  = {sel_id, OpRow, row_field};
            for (int k = 0; k < NUM_PE; k++) begin
              if (sel_id == 4'(k)) cnt_d[k] = 5'd1;
            end
          end
        end
      end
      StServe: begin
        if (in_valid && !req_bad) begin
          state_d     = StReply;
          out_valid_d = 1'b1;
          if (sel_cnt == OutDim) begin
            out_data_d = {sel_id, OpDone, 25'd0};
            for (int k = 0; k < NUM_PE; k++) begin
              if (sel_id == 4'(k)) fin_d[k] = 1'b1;
            end
          end else begin
            out_data_d = {sel_id, OpRow, row_field};
            for (int k = 0; k < NUM_PE; k++) begin
              if (sel_id == 4'(k)) cnt_d[k] = sel_cnt + 5'd1;
            end
          end
        end
      end
      StReply: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (&fin_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StServe;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pe_q        <= '0;
      for (int k = 0; k < NUM_PE; k++) cnt_q[k] <= '0;
      fin_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pe_q        <= pe_d;
      cnt_q       <= cnt_d;
      fin_q       <= fin_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

`ifdef IMEM_REQ_CHECK_EN
  localparam logic [3:0] ImemId = 4'(IMEM_ID);
  localparam logic [3:0] NumPe  = 4'(NUM_PE);
  logic err_q;

  assign req_bad = (in_data[32:29] != ImemId) || (in_data[28:25] != 4'd0) ||
                   (in_data[3:0] >= NumPe);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == StServe) && in_valid && req_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

  logic unused_bits;
  assign unused_bits = ^in_data[24:4];
`else
  assign req_bad = 1'b0;
  assign err     = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{in_data[32:25], in_data[24:4], 4'(IMEM_ID)};
`endif

  assign in_ready  = (state_q == StServe);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_imem_server.sv
module tb_imem_server;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_row = '0;
  logic [24:0] ld_data = '0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [32:0] out_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  logic [24:0] mrow [25];
  int          mcnt [5];
  bit          mfin [5];

  imem_server dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_en     (ld_en),
    .ld_row    (ld_row),
    .ld_data   (ld_data),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every reply handshake is compared against the oldest expected packet.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL reply_unexpected got %h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL reply_data got %h expected %h", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input int r, input logic [24:0] d);
    ld_en   = 1'b1;
    ld_row  = 5'(r);
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      mcnt[k] = 0;
      mfin[k] = 1'b0;
    end
  endtask

  function automatic logic [32:0] model_reply(input int id);
    logic [32:0] p;
    if (mcnt[id] == 21) begin
      mfin[id] = 1'b1;
      p = {4'(id), 4'd2, 25'd0};
    end else begin
      p = {4'(id), 4'd1, mrow[id + mcnt[id]]};
      mcnt[id]++;
    end
    return p;
  endfunction

  function automatic bit model_all_fin();
    bit a = 1'b1;
    for (int k = 0; k < 5; k++) a &= mfin[k];
    return a;
  endfunction

  task automatic send_req(input logic [3:0] dest, input logic [3:0] op, input int id,
                          input bit expect_reply);
    int n = 0;
    in_valid = 1'b1;
    in_data  = {dest, op, 21'd0, 4'(id)};
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL req_accept_timeout in_ready=%0b expected 1 (id %0d)", in_ready, id);
      in_valid = 1'b0;
      return;
    end
    if (expect_reply) exp_q.push_back(model_reply(id));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 00000", {in_ready, out_valid, busy, done, err});
    end
    checks++;
    if (out_data !== 33'd0) begin
      errors++;
      $display("FAIL reset_out_data got %h expected 0", out_data);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b expected 0000", {in_ready, out_valid, busy, done});
    end
  endtask

  task automatic test_prime();
    out_ready = 1'b1;
    for (int r = 0; r < 25; r++) mrow[r] = 25'(r * 32'h10001);
    for (int r = 0; r < 25; r++) load_row(r, (r == 1) ? 25'h1ABCDEF : mrow[r]);
    // Row 1 rewritten in the same cycle as start: the pass must see the new value.
    ld_en   = 1'b1;
    ld_row  = 5'd1;
    ld_data = mrow[1];
    start   = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) exp_q.push_back(model_reply(k));
    step();
    ld_en = 1'b0;
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prime_bubble valid/busy got %b%b expected 01", out_valid, busy);
    end
    step();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data[32:29] !== 4'(p)) begin
        errors++;
        $display("FAIL prime_consecutive valid=%b dest=%0d expected valid=1 dest=%0d",
                 out_valid, out_data[32:29], p);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL prime_to_serve valid/in_ready got %b%b expected 01", out_valid, in_ready);
    end
    drain();
  endtask

  task automatic test_single_req();
    // Write while busy must be ignored; PE 2's next row is still the original row 3.
    load_row(3, 25'h0FFFFFF);
    send_req(4'd10, 4'd0, 2, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reply_latency valid/in_ready got %b%b expected 10", out_valid, in_ready);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [32:0] hold;
    out_ready = 1'b0;
    send_req(4'd10, 4'd0, 3, 1'b1);
    hold = out_data;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold v=%b data=%h rdy=%b expected v=1 data=%h rdy=0",
                 out_valid, out_data, in_ready, hold);
      end
      step();
    end
    out_ready = 1'b1;
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release valid/in_ready got %b%b expected 01", out_valid, in_ready);
    end
  endtask

  task automatic test_req_check();
`ifdef IMEM_REQ_CHECK_EN
    send_req(4'd9, 4'd0, 1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_dest_dropped v/err/rdy got %b%b%b expected 011",
               out_valid, err, in_ready);
    end
    send_req(4'd10, 4'd0, 1, 1'b1);
    drain();
`else
    send_req(4'd10, 4'd0, 1, 1'b1);
    drain();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied got %b expected 0", err);
    end
`endif
  endtask

  task automatic test_full_pass();
    bit rep_done = 1'b0;
    for (int round = 0; round < 22; round++) begin
      for (int k = 0; k < 5; k++) begin
        if (!mfin[k]) begin
          send_req(4'd10, 4'd0, k, 1'b1);
        end else if (!rep_done && !model_all_fin()) begin
          // A finished PE asking again gets another done packet.
          send_req(4'd10, 4'd0, k, 1'b1);
          rep_done = 1'b1;
        end
      end
    end
    drain();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pass_done done/busy/rdy got %b%b%b expected 100", done, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_reply();
    out_ready = 1'b1;
    start     = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) exp_q.push_back(model_reply(k));
    step();
    start = 1'b0;
    drain();
    out_ready = 1'b0;
    send_req(4'd10, 4'd0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 33'd0) begin
      errors++;
      $display("FAIL reset_async v/busy/rdy got %b%b%b data=%h expected 000 data=0",
               out_valid, busy, in_ready, out_data);
    end
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    start     = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) exp_q.push_back(model_reply(k));
    step();
    start = 1'b0;
    drain();
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_serve rdy/done got %b%b expected 10", in_ready, done);
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_single_req();
    test_backpressure();
    test_req_check();
    test_full_pass();
    test_reset_mid_reply();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
